// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive byte FIFO with sticky overrun and irq level
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_end,
  input  logic [7:0]        rx_data,
  input  logic              pop,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr,
  input  logic              flush,
  output logic              irq_rx
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop_ok, ovr_set;
  logic [ADDR_W:0]   next_count;
  assign empty      = count == '0;
  assign full       = count == (ADDR_W+1)'(DEPTH);
  // a pop frees a slot on the same edge, so a full FIFO still accepts rx_end with pop
  assign push       = rx_end & (~full | pop);
  assign pop_ok     = pop & ~empty;
  assign ovr_set    = rx_end & full & ~pop;
  assign next_count = flush ? '0 : count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop_ok);
  assign rd_data    = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push && !flush && !reset) mem[wr_ptr] <= rx_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      irq_rx  <= 1'b0;
    end else begin
      wr_ptr  <= flush ? '0 : push   ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr  <= flush ? '0 : pop_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count   <= next_count;
      overrun <= ovr_set | (overrun & ~ovr_clr);
      irq_rx  <= next_count >= (ADDR_W+1)'(THRESH);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus random stimulus against a queue-based reference model
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, rx_end, pop, ovr_clr, flush;
  logic [7:0] rx_data, rd_data;
  logic       empty, full, overrun, irq_rx;
  logic [4:0] count;
  int         errors = 0, checks = 0;
  logic [7:0] q[$];
  bit         m_ovr;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .THRESH(1)) dut (
    .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data), .pop(pop),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .ovr_clr(ovr_clr), .flush(flush), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int n = q.size();
    chk({ph, ".count"},   32'(count),   32'(n));
    chk({ph, ".empty"},   32'(empty),   32'(n == 0));
    chk({ph, ".full"},    32'(full),    32'(n == 16));
    chk({ph, ".irq"},     32'(irq_rx),  32'(n >= 1));
    chk({ph, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({ph, ".rd_data"}, 32'(rd_data), n > 0 ? 32'(q[0]) : 32'h0);
  endtask

  task automatic step(input string ph, input bit re, input logic [7:0] d, input bit p,
                      input bit oc = 1'b0, input bit fl = 1'b0, input bit rs = 1'b0);
    bit was_full = q.size() == 16;
    bit do_pop   = p && q.size() > 0;
    bit do_push  = re && (!was_full || p);
    reset = rs; rx_end = re; rx_data = d; pop = p; ovr_clr = oc; flush = fl;
    if (rs) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (fl) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
      end
      m_ovr = (re && was_full && !p) || (m_ovr && !oc);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; rx_end = 1'b0; pop = 1'b0; ovr_clr = 1'b0; flush = 1'b0; rx_data = 8'hxx;
    check_all(ph);
  endtask

  initial begin
    reset = 1'b1; rx_end = 1'b0; rx_data = 8'h00; pop = 1'b0; ovr_clr = 1'b0; flush = 1'b0;
    q.delete(); m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
    step("idle", 1'b0, 8'h00, 1'b0);
    chk("idle.rd_zero", 32'(rd_data), 32'h0);

    step("push_a5", 1'b1, 8'hA5, 1'b0);
    chk("a5.rd", 32'(rd_data), 32'hA5);
    chk("a5.irq", 32'(irq_rx), 32'h1);
    step("pop_a5", 1'b0, 8'h00, 1'b1);
    chk("a5.empty", 32'(empty), 32'h1);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
    chk("fill.full", 32'(full), 32'h1);
    step("ovr", 1'b1, 8'hFF, 1'b0);
    chk("ovr.flag", 32'(overrun), 32'h1);
    chk("ovr.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.order", 32'(rd_data), 32'(i));
      step("drain", 1'b0, 8'h00, 1'b1);
    end
    chk("drain.empty", 32'(empty), 32'h1);
    step("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr.flag", 32'(overrun), 32'h0);

    for (int i = 0; i < 40; i++) begin
      step("wrap_push", 1'b1, 8'(8'h10 + i), 1'b0);
      chk("wrap.order", 32'(rd_data), 32'(8'h10 + i));
      step("wrap_pop", 1'b0, 8'h00, 1'b1);
    end

    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'(8'h20 + i), 1'b0);
    step("full_pp", 1'b1, 8'hC3, 1'b1);
    chk("full_pp.count", 32'(count), 32'd16);
    chk("full_pp.ovr", 32'(overrun), 32'h0);
    for (int i = 1; i < 16; i++) begin
      chk("full_pp.order", 32'(rd_data), 32'(8'h20 + i));
      step("full_pp_pop", 1'b0, 8'h00, 1'b1);
    end
    chk("full_pp.c3", 32'(rd_data), 32'hC3);

    step("flush0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, 8'(8'h40 + i), 1'b0);
    step("flush_rx", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("flush.count", 32'(count), 32'h0);
    chk("flush.empty", 32'(empty), 32'h1);

    for (int i = 0; i < 16; i++) step("fill3", 1'b1, 8'(8'h60 + i), 1'b0);
    step("ovr_vs_clr", 1'b1, 8'h77, 1'b0, 1'b1);
    chk("ovr_vs_clr.flag", 32'(overrun), 32'h1);

    step("flush1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step("seven", 1'b1, 8'(8'h80 + i), 1'b0);
    step("reset_mid", 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst.count", 32'(count), 32'h0);
    chk("rst.ovr", 32'(overrun), 32'h0);
    chk("rst.rd", 32'(rd_data), 32'h0);

    for (int i = 0; i < 600; i++)
      step("rand", $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the UART control/register block.
- Captures each byte the receiver completes (rx_end strobe plus rx_data) into a DEPTH-entry FIFO.
- Presents the oldest byte first-word-fall-through to the control block, which pops it on a CPU read.
- Generates the receive interrupt level and a sticky overrun flag, so back-to-back frames are not lost while the CPU is slow to service irq_rx.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
THRESH, 1, irq_rx asserts when count >= THRESH; legal range 1..DEPTH

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
rx_end  in  1  one-cycle strobe from receiver: rx_data holds a completed byte
rx_data  in  8  received byte, valid only when rx_end=1
pop  in  1  one-cycle strobe from control block: discard head entry
rd_data  out  8  head entry (oldest byte); 8'h00 when empty
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds DEPTH entries
count  out  ADDR_W+1  number of stored entries, 0..DEPTH
overrun  out  1  sticky: a byte arrived while full and was dropped
ovr_clr  in  1  one-cycle strobe: clear overrun
flush  in  1  one-cycle strobe: discard all entries
irq_rx  out  1  registered interrupt level, count >= THRESH

Behaviour:
- One clock domain, with one clock and a synchronous active-high reset.
- Reset: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, irq_rx=0, rd_data=8'h00. Storage contents are don't-care.
- Reset asserted mid-operation discards all data on that edge. The FIFO is empty from the next cycle.
- Storage: DEPTH x 8 register array. wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH (DEPTH-1 -> 0).
- count is a separate register. empty = (count==0), full = (count==DEPTH); both are derived from the registered count.
- push = rx_end & (~full | pop). Write rx_data at wr_ptr, then wr_ptr+1.
- pop_ok = pop & ~empty. rd_ptr+1 on the edge. A pop while empty is ignored: no pointer or count change.
- count update: +1 on push only, -1 on pop_ok only, unchanged when both occur or neither occurs.
- Simultaneous push and pop when full: both are accepted, count stays DEPTH, no overrun.
- Simultaneous push and pop when empty: push accepted, pop ignored, count becomes 1.
- Overrun: rx_end & full & ~pop sets overrun on that edge and the byte is dropped. The FIFO contents are unchanged.
- ovr_clr clears overrun. If a set and ovr_clr occur in the same cycle, the set wins.
- Flush:
  - count=0, wr_ptr=rd_ptr=0 on the edge.
  - Flush overrides push and pop in the same cycle, and the incoming byte is discarded.
  - overrun is unaffected.
- Latency:
  - A byte pushed at edge N is visible on rd_data with empty=0 in the cycle after edge N.
  - pop at edge N presents the next entry, or 8'h00 with empty=1, after edge N.
- rd_data is combinational from storage[rd_ptr] gated by ~empty, with no extra register stage.
- irq_rx is registered: next value = (next_count >= THRESH), so it tracks count with no added lag. It is a level and is not cleared by ovr_clr.
- Data order is strictly FIFO. No entry is ever duplicated or reordered across pointer wrap.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, overrun=0, irq_rx=0, rd_data=8'h00.
- Push 8'hA5 -> next cycle empty=0, count=1, rd_data=8'hA5, irq_rx=1 (THRESH=1). Pop -> empty=1, rd_data=8'h00, irq_rx=0.
- Push 16 bytes 8'h00..8'h0F -> full=1, count=16. 17th push 8'hFF -> overrun=1, count=16. Pop 16 times -> rd_data sequence 8'h00..8'h0F, then empty=1. ovr_clr -> overrun=0.
- Pointer wrap: push and pop alternately 40 bytes 8'h10..8'h37 -> each byte read back in order, count never exceeds 1.
- Full plus simultaneous rx_end/pop with 8'hC3 -> count stays 16, overrun=0, and 8'hC3 is read as the 16th byte after the prior 15.
- Corner collisions:
  - flush together with rx_end 8'h55 while count=5 -> count=0, empty=1, 8'h55 discarded.
  - rx_end while full together with ovr_clr -> overrun=1.
  - reset asserted with count=7 -> all outputs at reset values next cycle.
